// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_sequencer_if
//  Description : Bundle of the instruction-memory fetch handshake, the
//                execute-completion / branch-decision inputs and the
//                status/counter outputs of pc_fetch_sequencer.
//                master modport : the sequencer side.
//                slave  modport : memory + datapath side (environment).
//  Signals     : imem_req/imem_addr/imem_ready/imem_rdata  fetch handshake
//                instr/instr_valid                          decode hand-off
//                exec_done/stall/NextPCSrc/br_target        execute result
//                pc/pc_plus4                                PC visibility
//                misalign_err/retired_cnt/taken_cnt         status/counters
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_sequencer_if #(
  parameter int CNT_W = 32
);

  // Instruction memory fetch handshake
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;

  // Decode hand-off
  logic [31:0]      instr;
  logic             instr_valid;

  // Execute completion and next-PC decision
  logic             exec_done;
  logic             stall;
  logic             NextPCSrc;
  logic [31:0]      br_target;

  // PC visibility, status and performance counters
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             misalign_err;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
           pc, pc_plus4, misalign_err, retired_cnt, taken_cnt,
    input  imem_ready, imem_rdata, exec_done, stall, NextPCSrc, br_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
           pc, pc_plus4, misalign_err, retired_cnt, taken_cnt,
    output imem_ready, imem_rdata, exec_done, stall, NextPCSrc, br_target
  );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_sequencer
//  Description : Owns the program counter. Each instruction is fetched from
//                instruction memory, held stable for decode/execute, then the
//                next PC is chosen from the branch unit decision (pc+4 or
//                br_target). A taken branch to a non word-aligned target
//                freezes the sequencer in a trap state until reset. Also
//                counts retired instructions and taken redirects.
//  Ports       : clk  - core clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - pc_fetch_sequencer_if.master (fetch handshake,
//                       execute result inputs, pc/status/counter outputs)
//  Parameters  : RESET_PC - PC after reset, must be 4-byte aligned
//                CNT_W    - width of the performance counters (>= 1)
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  wire                       clk,
  input  wire                       rst,
  pc_fetch_sequencer_if.master      bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,        state_d;
  logic [31:0]      pc_q,           pc_d;
  logic [31:0]      instr_q,        instr_d;
  logic             instr_valid_q,  instr_valid_d;
  logic             misalign_q,     misalign_d;
  logic [CNT_W-1:0] retired_cnt_q,  retired_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,    taken_cnt_d;

  logic [31:0]      pc_plus4;
  logic             exec_accept;

  // Wraps modulo 2^32 naturally (0xFFFF_FFFC -> 0x0000_0000).
  assign pc_plus4    = pc_q + 32'd4;

  // The only cycle on which NextPCSrc/br_target are looked at.
  assign exec_accept = (state_q == S_EXEC) && bus.exec_done && !bus.stall;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    retired_cnt_d = retired_cnt_q;
    taken_cnt_d   = taken_cnt_q;

    case (state_q)
      S_FETCH: begin
        // imem_rdata is only captured on the accepting cycle.
        if (bus.imem_ready) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end

      S_EXEC: begin
        if (exec_accept) begin
          instr_valid_d = 1'b0;
          if (!bus.NextPCSrc) begin
            pc_d          = pc_plus4;
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
            state_d       = S_FETCH;
          end else if (bus.br_target[1:0] == 2'b00) begin
            pc_d          = bus.br_target;
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
            taken_cnt_d   = taken_cnt_q + CNT_W'(1);
            state_d       = S_FETCH;
          end else begin
            // Misaligned redirect: keep the faulting instruction's PC for
            // post-mortem and do not count it as retired.
            misalign_d    = 1'b1;
            state_d       = S_TRAP;
          end
        end
      end

      S_TRAP: begin
        // Frozen; only rst leaves this state.
        instr_valid_d = 1'b0;
      end

      default: begin
        // Unreachable encoding: park in the trap state rather than run with
        // an unknown instruction.
        instr_valid_d = 1'b0;
        state_d       = S_TRAP;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      retired_cnt_q <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      retired_cnt_q <= retired_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state or registered, except pc_plus4. imem_req
  // depends on state only, so exec_done/NextPCSrc never reach it
  // combinationally.
  // --------------------------------------------------------------------------
  assign bus.imem_req     = (state_q == S_FETCH);
  assign bus.imem_addr    = pc_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.misalign_err = misalign_q;
  assign bus.retired_cnt  = retired_cnt_q;
  assign bus.taken_cnt    = taken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_sequencer
//  Description : Directed self-checking bench for pc_fetch_sequencer with
//                RESET_PC = 0x100: reset, sequential flow, taken branch,
//                memory wait / stall, misaligned trap, PC wrap and reset
//                during execute.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pc_fetch_sequencer_if #(.CNT_W(32)) bus ();

  pc_fetch_sequencer #(
    .RESET_PC (RST_PC),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before checking / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst            = 1'b1;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.exec_done  = 1'b0;
    bus.stall      = 1'b0;
    bus.NextPCSrc  = 1'b0;
    bus.br_target  = 32'd0;

    // ---------------- T1: reset ----------------
    step();
    step();
    rst = 1'b0;
    chk("t1_pc",       bus.pc,           32'h100);
    chk("t1_addr",     bus.imem_addr,    32'h100);
    chk("t1_req",      bus.imem_req,     32'd1);
    chk("t1_valid",    bus.instr_valid,  32'd0);
    chk("t1_instr",    bus.instr,        32'd0);
    chk("t1_misalign", bus.misalign_err, 32'd0);
    chk("t1_retired",  bus.retired_cnt,  32'd0);
    chk("t1_taken",    bus.taken_cnt,    32'd0);
    chk("t1_plus4",    bus.pc_plus4,     32'h104);

    // ---------------- T2: three sequential instructions ----------------
    bus.imem_ready = 1'b1;
    bus.exec_done  = 1'b1;
    bus.NextPCSrc  = 1'b0;
    bus.imem_rdata = 32'h1111_0001;
    step();  // fetch accepted
    chk("t2_i0_valid", bus.instr_valid, 32'd1);
    chk("t2_i0_instr", bus.instr,       32'h1111_0001);
    chk("t2_i0_req",   bus.imem_req,    32'd0);
    chk("t2_i0_pc",    bus.pc,          32'h100);
    step();  // retire
    chk("t2_pc1",      bus.pc,          32'h104);
    chk("t2_req1",     bus.imem_req,    32'd1);
    chk("t2_valid1",   bus.instr_valid, 32'd0);
    chk("t2_ret1",     bus.retired_cnt, 32'd1);
    bus.imem_rdata = 32'h1111_0002;
    step();
    chk("t2_i1_instr", bus.instr,       32'h1111_0002);
    step();
    chk("t2_pc2",      bus.pc,          32'h108);
    bus.imem_rdata = 32'h1111_0003;
    step();
    step();
    chk("t2_pc3",      bus.pc,          32'h10C);
    chk("t2_ret3",     bus.retired_cnt, 32'd3);
    chk("t2_taken0",   bus.taken_cnt,   32'd0);

    // ---------------- T3: taken branch at pc=0x104 ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t3_rst_ret",  bus.retired_cnt, 32'd0);
    chk("t3_rst_pc",   bus.pc,          32'h100);
    step();  // fetch 0x100
    step();  // retire -> 0x104
    chk("t3_pc104",    bus.pc,          32'h104);
    step();  // fetch 0x104
    bus.NextPCSrc = 1'b1;
    bus.br_target = 32'h0000_0080;
    step();  // retire, redirect
    chk("t3_addr",     bus.imem_addr,   32'h080);
    chk("t3_taken",    bus.taken_cnt,   32'd1);
    chk("t3_retired",  bus.retired_cnt, 32'd2);
    chk("t3_req",      bus.imem_req,    32'd1);

    // ---------------- T4: memory wait then stall ----------------
    bus.NextPCSrc  = 1'b0;
    bus.imem_ready = 1'b0;
    bus.exec_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_wait_pc",    bus.pc,          32'h080);
      chk("t4_wait_req",   bus.imem_req,    32'd1);
      chk("t4_wait_valid", bus.instr_valid, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hCAFE_0080;
    bus.stall      = 1'b1;
    step();  // fetch accepted
    chk("t4_instr",    bus.instr,       32'hCAFE_0080);
    bus.imem_rdata = 32'hDEAD_BEEF;  // must not be captured in S_EXEC
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_stall_pc",    bus.pc,          32'h080);
      chk("t4_stall_instr", bus.instr,       32'hCAFE_0080);
      chk("t4_stall_valid", bus.instr_valid, 32'd1);
      chk("t4_stall_ret",   bus.retired_cnt, 32'd2);
    end
    bus.stall = 1'b0;
    step();
    chk("t4_pc",       bus.pc,          32'h084);
    chk("t4_ret",      bus.retired_cnt, 32'd3);
    chk("t4_taken",    bus.taken_cnt,   32'd1);

    // ---------------- T5: misaligned taken target ----------------
    bus.imem_rdata = 32'h5555_0084;
    bus.NextPCSrc  = 1'b1;
    bus.br_target  = 32'h0000_0102;
    step();  // fetch 0x084
    step();  // trap
    chk("t5_misalign", bus.misalign_err, 32'd1);
    chk("t5_req",      bus.imem_req,     32'd0);
    chk("t5_valid",    bus.instr_valid,  32'd0);
    chk("t5_pc",       bus.pc,           32'h084);
    chk("t5_ret",      bus.retired_cnt,  32'd3);
    chk("t5_taken",    bus.taken_cnt,    32'd1);
    bus.NextPCSrc = 1'b0;
    step();
    step();
    chk("t5_hold_req", bus.imem_req,     32'd0);
    chk("t5_hold_pc",  bus.pc,           32'h084);
    chk("t5_hold_err", bus.misalign_err, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_clr_err",  bus.misalign_err, 32'd0);
    chk("t5_clr_pc",   bus.pc,           32'h100);
    chk("t5_clr_req",  bus.imem_req,     32'd1);

    // ---------------- T6: PC wrap, reset during execute ----------------
    bus.NextPCSrc = 1'b1;
    bus.br_target = 32'hFFFF_FFFC;
    step();  // fetch 0x100
    step();  // jump to 0xFFFF_FFFC
    chk("t6_pc_top",   bus.pc,          32'hFFFF_FFFC);
    chk("t6_plus4",    bus.pc_plus4,    32'h0000_0000);
    bus.NextPCSrc = 1'b0;
    step();
    step();
    chk("t6_wrap_pc",  bus.pc,          32'h0000_0000);
    chk("t6_wrap_ret", bus.retired_cnt, 32'd2);
    chk("t6_wrap_tk",  bus.taken_cnt,   32'd1);
    step();  // fetch at 0 -> S_EXEC
    chk("t6_exec",     bus.instr_valid, 32'd1);
    rst = 1'b1;      // exec_done is also high: reset must win
    step();
    rst = 1'b0;
    chk("t6_rst_pc",   bus.pc,          32'h100);
    chk("t6_rst_ret",  bus.retired_cnt, 32'd0);
    chk("t6_rst_val",  bus.instr_valid, 32'd0);
    chk("t6_rst_req",  bus.imem_req,    32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
